// File: rtl/dmem_responder_pkg.sv
// Shared constants for the multi-cycle data-memory responder: FSM encodings and the
// default wait-state count.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } dmem_state_e;

    localparam int unsigned DMEM_WAIT_STATES = 2;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word RAM: synchronous write, combinational read, contents never reset.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                     clock,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: inserts WAIT_STATES stall cycles plus one completion cycle
// per access. Optional DMEM_MISALIGN_CHECK_EN suppresses misaligned accesses and adds misalign.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = DMEM_WAIT_STATES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_stall,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              req_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_e       r_state, w_state_d;
    logic [3:0]        r_cnt, w_cnt_d;
    logic              r_wr, r_mis, r_req_err;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata, r_rdata;

    logic              w_req, w_accept, w_stall_raw, w_mis;
    logic [IDX_W-1:0]  w_idx;
    logic              w_done, w_op_wr, w_op_mis, w_we, w_load_done;
    logic [IDX_W-1:0]  w_op_idx;
    logic [DATA_W-1:0] w_op_wdata, w_arr_rdata, w_rdata_d;
    logic              w_unused_addr;

    assign w_req = MemRead | MemWrite;
    assign w_idx = addr[IDX_W+1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis = (addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    assign w_unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_accept    = 1'b0;
        w_stall_raw = 1'b0;
        if (WAIT_STATES != 0) begin
            case (r_state)
                StIdle, StDone: begin
                    w_state_d = StIdle;
                    if (w_req) begin
                        w_accept    = 1'b1;
                        w_stall_raw = 1'b1;
                        w_cnt_d     = CNT_INIT;
                        // The accept cycle is itself the first stall cycle.
                        w_state_d   = (WAIT_STATES == 1) ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    w_stall_raw = 1'b1;
                    w_cnt_d     = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_state_d = StDone;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else begin
            w_accept = w_req & reset;
        end
    end

    // Completion operands: latched copy when multi-cycle, live inputs when single-cycle.
    always_comb begin
        if (WAIT_STATES != 0) begin
            w_done     = (r_state == StDone);
            w_op_wr    = r_wr;
            w_op_mis   = r_mis;
            w_op_idx   = r_idx;
            w_op_wdata = r_wdata;
        end else begin
            w_done     = w_accept;
            w_op_wr    = MemWrite;
            w_op_mis   = w_mis;
            w_op_idx   = w_idx;
            w_op_wdata = wdata;
        end
    end

    assign w_we        = w_done & w_op_wr & ~w_op_mis;
    assign w_load_done = w_done & ~w_op_wr;
    assign w_rdata_d   = w_op_mis ? '0 : w_arr_rdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock   (clock),
        .i_we    (w_we),
        .i_addr  (w_op_idx),
        .i_wdata (w_op_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_mis     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_req_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_wr    <= MemWrite;
                r_mis   <= w_mis;
                r_idx   <= w_idx;
                r_wdata <= wdata;
                if (MemRead && MemWrite) begin
                    r_req_err <= 1'b1;
                end
            end
            if (w_load_done) begin
                r_rdata <= w_rdata_d;
            end
        end
    end

    assign rdata     = w_load_done ? w_rdata_d : r_rdata;
    assign mem_stall = reset & w_stall_raw;
    assign req_err   = r_req_err;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign  = w_done & w_op_mis;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a single-cycle instance share one stimulus
// stream and are each checked against an access-level reference model.
module tb_dmem_responder;

    localparam int unsigned W2 = 2;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        MemRead  = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr     = '0;
    logic [31:0] wdata    = '0;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0, err2, err0;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        mis2, mis0;
`endif

    always #5 clock = ~clock;

    dmem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH       (256),
        .WAIT_STATES (W2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata2),
        .mem_stall (stall2),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misalign  (mis2),
`endif
        .req_err   (err2)
    );

    dmem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH       (256),
        .WAIT_STATES (0)
    ) dut0 (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata0),
        .mem_stall (stall0),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misalign  (mis0),
`endif
        .req_err   (err0)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: memory images plus the access in flight on the wait-state instance.
    logic [31:0] m2 [256];
    logic [31:0] m0 [256];
    bit          act   = 1'b0;
    int          ph    = 0;
    bit          c_wr  = 1'b0;
    int          c_idx = 0;
    logic [31:0] c_d   = '0;
    logic [31:0] h2    = '0;
    logic [31:0] h0    = '0;
    bit          e2    = 1'b0;
    bit          e0    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, then advance the model.
    task automatic tick(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int idx;
        bit comp, acc;
        @(posedge clock);
        #1;
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wdata    = d;
        @(negedge clock);
        idx  = int'(a[9:2]);
        comp = act && (ph == W2);
        acc  = (!act || comp) && (rd || wr);
        chk("stall2", stall2, (act && ph < W2) || acc);
        chk("rdata2", rdata2, (comp && !c_wr) ? m2[c_idx] : h2);
        chk("err2", err2, e2);
        chk("stall0", stall0, 0);
        chk("rdata0", rdata0, (rd && !wr) ? m0[idx] : h0);
        chk("err0", err0, e0);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis2", mis2, 0);
        chk("mis0", mis0, 0);
`endif
        if (act && ph < W2) begin
            ph++;
        end else if (comp) begin
            if (c_wr) m2[c_idx] = c_d;
            else      h2 = m2[c_idx];
            act = 1'b0;
        end
        if (acc) begin
            act   = 1'b1;
            ph    = 1;
            c_wr  = wr;
            c_idx = idx;
            c_d   = d;
            e2    = e2 | (rd && wr);
        end
        if (wr)      m0[idx] = d;
        else if (rd) h0 = m0[idx];
        e0 = e0 | (rd && wr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #2;
        chk("rst_stall2", stall2, 0);
        chk("rst_rdata2", rdata2, 0);
        chk("rst_err2", err2, 0);
        chk("rst_rdata0", rdata0, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            idle(2);
        end

        // Store then load of the same word, each taking two stall cycles and one completion.
        tick(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        chk("sw_stall_c0", stall2, 1);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sw_stall_c1", stall2, 1);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sw_stall_done", stall2, 0);
        tick(1'b1, 1'b0, 32'h20, 32'h0);
        idle(2);
        chk("lw20", rdata2, 32'h1234_5678);

        // Back-to-back loads with the request held high throughout.
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 32'h4, 32'h0);
        chk("b2b_first", rdata2, 32'hC0DE_0000);
        chk("b2b_restall", stall2, 1);
        tick(1'b1, 1'b0, 32'h4, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("b2b_second", rdata2, 32'hC0DE_0001);

        // Address 0x400 wraps to word 0.
        tick(1'b0, 1'b1, 32'h400, 32'hA11A_5000);
        idle(2);
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        idle(2);
        chk("alias", rdata2, 32'hA11A_5000);

        // Simultaneous read and write: store wins, error flag sticks.
        tick(1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5);
        idle(2);
        chk("req_err2", err2, 1);
        chk("req_err0", err0, 1);
        tick(1'b1, 1'b0, 32'h8, 32'h0);
        idle(2);
        chk("both_store", rdata2, 32'hA5A5_A5A5);
        chk("req_err_sticky", err2, 1);

        // Single-cycle instance: store then load on consecutive cycles.
        tick(1'b0, 1'b1, 32'h30, 32'h5A5A_0001);
        tick(1'b1, 1'b0, 32'h30, 32'h0);
        chk("w0_lw", rdata0, 32'h5A5A_0001);
        chk("w0_stall", stall0, 0);
        idle(2);

        // Reset in the middle of a pending store aborts it.
        tick(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(posedge clock);
        #2;
        reset    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
        chk("midrst_stall", stall2, 0);
        chk("midrst_rdata", rdata2, 0);
        chk("midrst_err", err2, 0);
        chk("midrst_rdata0", rdata0, 0);
        act = 1'b0;
        h2  = '0;
        h0  = '0;
        e2  = 1'b0;
        e0  = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick(1'b1, 1'b0, 32'h10, 32'h0);
        idle(2);
        chk("mem4_kept", rdata2, 32'hC0DE_0004);

        // Random traffic over the preloaded words with random upper (aliased) address bits.
        for (int n = 0; n < 300; n++) begin
            int r, widx;
            logic [31:0] a;
            r    = int'($urandom_range(0, 9));
            widx = int'($urandom_range(0, 15));
            a    = ($urandom & 32'hFFFF_FC00) | 32'(widx * 4);
            tick(r < 4 || r == 8, r >= 4 && r <= 8, a, $urandom);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder at the MEM stage, on the far side of the pipeline's MemRead/MemWrite request.
- Accepts one load or store per request, inserts a fixed number of wait states and drives mem_stall back to the pipeline (PC / IF-ID / ID-EX / EX-MEM write enables) until the access completes.
- Word-addressed RAM, stores at the completion edge.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width from EX/MEM.
- DEPTH, 256, number of words (power of two).
- WAIT_STATES, 2, stall cycles per access (0..15); 0 gives single-cycle behaviour.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  EX/MEM load request.
- MemWrite  in  1  EX/MEM store request.
- addr  in  ADDR_W  byte address (EX/MEM ALU result).
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load data to MEM/WB.
- mem_stall  out  1  freeze upstream pipeline registers.
- req_err  out  1  MemRead and MemWrite both high at accept (sticky until reset).

Behaviour:
- States: IDLE, BUSY, DONE. Reset (reset low, async): state=IDLE, cnt=0, rdata=0, req_err=0, mem_stall forced 0; memory contents not cleared.
- Word index = addr[log2(DEPTH)+1:2]; higher bits ignored (wrap-around); addr[1:0] ignored unless the optional feature is on.
- Accept: in IDLE or DONE, req = MemRead|MemWrite. If WAIT_STATES>0 and req: mem_stall=1 combinationally that same cycle; latch op/index/wdata; cnt<=WAIT_STATES-1; go BUSY.
- BUSY: mem_stall=1; inputs ignored (latched copy used); cnt decrements each cycle; at cnt==0 go DONE.
- DONE: mem_stall=0; rdata shows mem[latched index] for loads; store written at the DONE->next edge. The pipeline advances at the end of DONE, so a request seen in DONE is a new access: accept it as in IDLE (back-to-back), else go IDLE.
- Latency: WAIT_STATES stall cycles followed by 1 completion cycle, i.e. WAIT_STATES+1 cycles per access.
- WAIT_STATES=0: no FSM transitions. rdata = mem[index] combinationally; store at the request edge; mem_stall always 0.
- Both MemRead and MemWrite high: store takes priority; req_err<=1.
- rdata holds its last load value through stores, stalls and IDLE.
- Reset mid-BUSY: access aborted, store not performed.
- Load immediately after a store to the same word (back-to-back) returns the new data.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: accept with addr[1:0]!=0 completes with no store and rdata=0, still taking WAIT_STATES+1 cycles; adds output port misalign (1 bit), pulsed high for the completion cycle.
- Undefined: addr[1:0] ignored, no misalign port.

Decomposition:
- Shared constants header gains the FSM state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the default DMEM_WAIT_STATES.
- One natural sub-module: dmem_array (synchronous-write, combinational-read DEPTH x DATA_W RAM).
- The FSM/counter stays in dmem_responder.

Test Plan:
- Reset low mid-BUSY with a store of 0xDEADBEEF to addr 0x10 -> state IDLE, mem_stall=0, rdata=0, mem[4] unchanged.
- WAIT_STATES=2: SW 0x12345678 to 0x20, then LW 0x20 -> each access: mem_stall high 2 cycles, low 1; LW rdata=0x12345678 in its DONE cycle.
- Back-to-back LW 0x0 then LW 0x4 with requests held high -> two full 3-cycle accesses, no lost or merged request.
- Address 0x400 with DEPTH=256 -> aliases to word 0; a store there is read back via addr 0x0.
- MemRead=MemWrite=1, addr 0x8, wdata 0xA5A5A5A5 -> store performed, req_err=1 sticky until reset.
- WAIT_STATES=0: SW then LW on consecutive cycles -> mem_stall never high; LW returns the stored word same cycle.
